addsub_accumulator: RTL

ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

---
 rtl/addsub_accumulator.sv | 136 +++++++++++++
 1 files changed

// File: rtl/addsub_accumulator.sv
// Handshaked add/subtract accumulator with ALU-style flags and a saturating operation counter.
// One command per IDLE -> EXEC -> HOLD pass; results are held until the consumer takes them.
module addsub_accumulator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic [7:0]       op_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;

    logic             is_sub;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] low_sum;
    logic             msb_cin;

    logic [WIDTH-1:0] new_acc;
    logic             new_carry;
    logic             new_ovf;
    logic [CNT_W-1:0] new_cnt;

    // SUB reuses the adder as acc + ~data + 1; low_sum exposes the carry into the MSB.
    always_comb begin
        is_sub  = (op_q == OP_SUB);
        b_opnd  = is_sub ? ~data_q : data_q;
        sum     = {1'b0, acc} + {1'b0, b_opnd} + (WIDTH+1)'(is_sub);
        low_sum = {1'b0, acc[WIDTH-2:0]} + {1'b0, b_opnd[WIDTH-2:0]} + WIDTH'(is_sub);
        msb_cin = low_sum[WIDTH-1];
    end

    // Result selection for the captured command.
    always_comb begin
        new_acc   = acc;
        new_carry = 1'b0;
        new_ovf   = 1'b0;
        new_cnt   = op_count;
        case (op_q)
            OP_ADD, OP_SUB: begin
                new_acc   = sum[WIDTH-1:0];
                new_carry = sum[WIDTH];
                new_ovf   = msb_cin ^ sum[WIDTH];
                new_cnt   = (op_count == CNT_MAX) ? op_count : op_count + CNT_W'(1);
            end
            OP_LOAD: begin
                new_acc = data_q;
            end
            OP_CLEAR: begin
                new_acc = '0;
                new_cnt = '0;
            end
            default: begin
                new_acc = acc;
            end
        endcase
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            op_q      <= OP_ADD;
            data_q    <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            negative  <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    acc       <= new_acc;
                    carry     <= new_carry;
                    overflow  <= new_ovf;
                    zero      <= (new_acc == '0);
                    negative  <= new_acc[WIDTH-1];
                    op_count  <= new_cnt;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
